// File: rtl/song_block_walker.sv
// Upstream sequencer for song_block_inspector: steps the block index through the song,
// waits out the inspector latency, captures one feature window per block and streams it out.
module song_block_walker #(
    parameter int IDX_W     = 9,
    parameter int DATA_W    = 16,
    parameter int FIRST_IDX = 0,
    parameter int IDX_STEP  = 4,
    parameter int LAST_IDX  = 28,
    parameter int INSP_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      block_idx_out,
    input  logic [DATA_W-1:0]     f_in0,
    input  logic [DATA_W-1:0]     f_in1,
    input  logic [DATA_W-1:0]     f_in2,
    input  logic [DATA_W-1:0]     f_in3,
    input  logic [2:0]            block_size_in,
    input  logic [2:0]            prev_size_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [4*DATA_W-1:0]   m_feat,
    output logic [IDX_W-1:0]      m_block_idx,
    output logic [2:0]            m_block_size,
    output logic [2:0]            m_prev_size,
    output logic                  m_last,
    output logic [IDX_W-1:0]      m_count
);

    localparam int CNT_W = (INSP_LAT > 1) ? $clog2(INSP_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT  = CNT_W'(INSP_LAT);
    localparam logic [IDX_W:0]   LAST_EXT  = (IDX_W + 1)'(LAST_IDX);
    localparam logic [IDX_W:0]   STEP_EXT  = (IDX_W + 1)'(IDX_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W:0]   next_idx_s;
    logic             idx_is_last_s;
    logic             capture_s;
    logic             handshake_s;

    // Index arithmetic one bit wider so a step past the IDX_W range is seen as the end
    always_comb begin
        next_idx_s    = {1'b0, block_idx_out} + STEP_EXT;
        idx_is_last_s = ({1'b0, block_idx_out} == LAST_EXT) || (next_idx_s > LAST_EXT);
        capture_s     = (state_r == ST_WAIT) && (cnt_r == {CNT_W{1'b0}});
        handshake_s   = m_valid && m_ready;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (capture_s) begin
                    // A zero block size marks end of song; that block is never emitted
                    if (block_size_in == 3'd0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_OUT;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (handshake_s) begin
                    if (m_last) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            block_idx_out <= {IDX_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            m_valid       <= 1'b0;
            m_feat        <= {(4*DATA_W){1'b0}};
            m_block_idx   <= {IDX_W{1'b0}};
            m_block_size  <= 3'd0;
            m_prev_size   <= 3'd0;
            m_last        <= 1'b0;
            m_count       <= {IDX_W{1'b0}};
        end else begin
            busy <= (state_next_s == ST_WAIT) || (state_next_s == ST_OUT);
            done <= (state_next_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        block_idx_out <= IDX_W'(FIRST_IDX);
                        m_count       <= {IDX_W{1'b0}};
                        cnt_r         <= LAT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else if (block_size_in != 3'd0) begin
                        m_feat       <= {f_in3, f_in2, f_in1, f_in0};
                        m_block_idx  <= block_idx_out;
                        m_block_size <= block_size_in;
                        m_prev_size  <= prev_size_in;
                        m_last       <= idx_is_last_s;
                        m_valid      <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (handshake_s) begin
                        m_count <= m_count + IDX_W'(1);
                        m_valid <= 1'b0;
                        if (!m_last) begin
                            block_idx_out <= next_idx_s[IDX_W-1:0];
                            cnt_r         <= LAT_INIT;
                        end
                    end
                end
                ST_DONE: begin
                    m_valid <= 1'b0;
                end
                default: begin
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_block_walker.sv
// Self-checking bench for song_block_walker: inspector model, queue-based beat
// scoreboard checked every cycle, plus directed walks with literal expectations.
module tb_song_block_walker;

    localparam int IDX_W = 9;
    localparam int DATA_W = 16;
    localparam int FIRST_IDX = 0;
    localparam int IDX_STEP = 4;
    localparam int LAST_IDX = 28;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                busy, done, m_valid, m_last;
    logic                m_ready = 1'b1;
    logic [IDX_W-1:0]    block_idx_out, m_block_idx, m_count;
    logic [DATA_W-1:0]   f_in0, f_in1, f_in2, f_in3;
    logic [2:0]          block_size_in, prev_size_in, m_block_size, m_prev_size;
    logic [4*DATA_W-1:0] m_feat;

    song_block_walker #(
        .IDX_W(IDX_W), .DATA_W(DATA_W), .FIRST_IDX(FIRST_IDX),
        .IDX_STEP(IDX_STEP), .LAST_IDX(LAST_IDX), .INSP_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .block_idx_out(block_idx_out),
        .f_in0(f_in0), .f_in1(f_in1), .f_in2(f_in2), .f_in3(f_in3),
        .block_size_in(block_size_in), .prev_size_in(prev_size_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_feat(m_feat),
        .m_block_idx(m_block_idx), .m_block_size(m_block_size),
        .m_prev_size(m_prev_size), .m_last(m_last), .m_count(m_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] feat;
        int          idx;
        logic [2:0]  sz;
        logic [2:0]  prv;
        logic        last;
    } beat_t;

    beat_t      exp_q[$];
    logic [2:0] size_tbl[8];
    int         n_pass = 0;
    int         n_total = 0;
    int         accepted = 0;
    int         stall_idx = -1;
    int         stall_len = 0;
    int         stalled = 0;
    logic       done_pending = 1'b0;
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fw(input int idx, input int k);
        return 16'(idx * 16 + k);
    endfunction

    function automatic logic [2:0] size_of(input int i);
        if (i % 4 == 0 && i / 4 < 8 && i >= 0) return size_tbl[i / 4];
        return 3'd0;
    endfunction

    function automatic logic [2:0] prev_of(input int i);
        if (i == 0) return 3'd0;
        return size_of(i - IDX_STEP);
    endfunction

    // Inspector model: outputs follow block_idx with one cycle of latency
    initial begin
        int last_idx;
        last_idx = 0;
        for (int k = 0; k < 8; k++) size_tbl[k] = 3'd4;
        forever begin
            f_in0 = fw(last_idx, 0); f_in1 = fw(last_idx, 1);
            f_in2 = fw(last_idx, 2); f_in3 = fw(last_idx, 3);
            block_size_in = size_of(last_idx);
            prev_size_in = prev_of(last_idx);
            @(posedge clk); #1;
            last_idx = int'(block_idx_out);
        end
    end

    // Downstream ready: stalls the beat at stall_idx for stall_len cycles
    initial begin
        forever begin
            @(posedge clk); #1;
            if (m_valid && int'(m_block_idx) == stall_idx && stalled < stall_len) begin
                m_ready = 1'b0;
                stalled++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Scoreboard compare on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
                done_pending = 1'b0;
            end else begin
                if (done_pending) begin
                    check("done_after_last", 64'(done), 64'd1);
                    done_pending = 1'b0;
                end
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(m_block_idx), 64'hFFFF);
                    end else begin
                        check("m_feat", m_feat, exp_q[0].feat);
                        check("m_block_idx", 64'(m_block_idx), 64'(exp_q[0].idx));
                        check("block_idx_out", 64'(block_idx_out), 64'(exp_q[0].idx));
                        check("m_block_size", 64'(m_block_size), 64'(exp_q[0].sz));
                        check("m_prev_size", 64'(m_prev_size), 64'(exp_q[0].prv));
                        check("m_last", 64'(m_last), 64'(exp_q[0].last));
                        check("m_count", 64'(m_count), 64'(accepted));
                        check("busy_in_beat", 64'(busy), 64'd1);
                        if (m_ready) begin
                            if (exp_q[0].last) done_pending = 1'b1;
                            void'(exp_q.pop_front());
                            accepted++;
                        end
                    end
                end
                if (done) begin
                    check("done_queue_empty", 64'(exp_q.size()), 64'd0);
                    check("done_busy_low", 64'(busy), 64'd0);
                    if (prev_done) check("done_width", 64'(prev_done), 64'd0);
                end
                prev_done = done;
            end
        end
    end

    task automatic build_walk();
        beat_t b;
        exp_q.delete();
        accepted = 0;
        for (int i = FIRST_IDX; i <= LAST_IDX; i += IDX_STEP) begin
            if (size_of(i) == 3'd0) break;
            b.feat = {fw(i, 3), fw(i, 2), fw(i, 1), fw(i, 0)};
            b.idx  = i;
            b.sz   = size_of(i);
            b.prv  = prev_of(i);
            b.last = (i + IDX_STEP > LAST_IDX);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        if (!done) check("timeout_done", 64'd0, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_idx"}, 64'(block_idx_out), 64'd0);
        check({tag, "_m_count"}, 64'(m_count), 64'd0);
        check({tag, "_m_feat"}, m_feat, 64'd0);
        check({tag, "_m_last"}, 64'(m_last), 64'd0);
        check({tag, "_m_block_idx"}, 64'(m_block_idx), 64'd0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Full walk, sizes 4, ready always high
        build_walk();
        pulse_start();
        wait_done();
        @(negedge clk);
        check("walk1_count", 64'(m_count), 64'd8);
        check("walk1_accepted", 64'(accepted), 64'd8);
        check("walk1_last_idx", 64'(m_block_idx), 64'd28);
        check("walk1_m_last", 64'(m_last), 64'd1);
        check("walk1_feat", m_feat, 64'h01C3_01C2_01C1_01C0);
        check("walk1_size", 64'(m_block_size), 64'd4);

        // Backpressure on idx 8, start pulsed while busy and during DONE
        stalled = 0; stall_len = 5; stall_idx = 8;
        build_walk();
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("start_in_done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("start_in_done_busy2", 64'(busy), 64'd0);
        check("walk2_stall_cycles", 64'(stalled), 64'd5);
        check("walk2_count", 64'(m_count), 64'd8);
        stall_idx = -1;

        // End-of-song marker at idx 12
        size_tbl[0] = 3'd3; size_tbl[1] = 3'd5; size_tbl[2] = 3'd2; size_tbl[3] = 3'd0;
        build_walk();
        check("model_marker_beats", 64'(exp_q.size()), 64'd3);
        pulse_start();
        wait_done();
        @(negedge clk);
        check("marker_count", 64'(m_count), 64'd3);
        check("marker_no_last", 64'(m_last), 64'd0);
        check("marker_idx", 64'(m_block_idx), 64'd8);
        check("marker_size", 64'(m_block_size), 64'd2);
        check("marker_prev", 64'(m_prev_size), 64'd5);
        check("marker_feat", m_feat, 64'h0083_0082_0081_0080);
        for (int k = 0; k < 8; k++) size_tbl[k] = 3'd4;

        // Reset while a beat at idx 16 is held
        stalled = 0; stall_len = 1000; stall_idx = 16;
        build_walk();
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_valid && m_block_idx == 9'd16) && n < 200);
        check("reach_idx16", 64'(m_block_idx), 64'd16);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        stall_idx = -1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(m_valid), 64'd0);

        // Restart begins again at idx 0
        build_walk();
        pulse_start();
        wait_done();
        @(negedge clk);
        check("restart_count", 64'(m_count), 64'd8);
        check("restart_accepted", 64'(accepted), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
